fpu_bf16_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single bfloat16 FPU datapath between `NREQ` requesters, for example the Wishbone management port and the UART-loaded instruction streamer. It accepts one operation at a time over a valid/ready handshake and issues it to the FPU as a one-cycle start pulse. It waits for the FPU's done strobe, with a timeout, and returns the result and flags to the requester that issued the operation. It sits between the requester front-ends and the FPU core, inside the user project area.

---
 rtl/fpu_bf16_pkg.sv | 40 ++++
 rtl/fpu_bf16_arbiter_rr.sv | 31 +++
 rtl/fpu_bf16_arbiter.sv | 157 +++++++++++++++
 tb/tb_fpu_bf16_arbiter.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_bf16_pkg.sv
// Shared types and constants for the bf16 FPU arbiter slice.
// States, field widths, canonical NaN and response flag layout.
package fpu_bf16_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    localparam int OP_W    = 5;
    localparam int FLAG_W  = 5;
    localparam int RFLAG_W = FLAG_W + 1;
    localparam int DATA_W  = 16;

    localparam logic [DATA_W-1:0] BF16_QNAN = 16'h7FC0;

    // Response flag bit positions: {timeout, NV, DZ, OF, UF, NX}
    localparam int FLG_NX = 0;
    localparam int FLG_UF = 1;
    localparam int FLG_OF = 2;
    localparam int FLG_DZ = 3;
    localparam int FLG_NV = 4;
    localparam int FLG_TO = 5;

    localparam logic [OP_W-1:0] OP_FADD = 5'd0;
    localparam logic [OP_W-1:0] OP_FSUB = 5'd1;
    localparam logic [OP_W-1:0] OP_FMUL = 5'd2;
    localparam logic [OP_W-1:0] OP_FMA  = 5'd3;

    function automatic logic [RFLAG_W-1:0] timeout_flags();
        logic [RFLAG_W-1:0] f;
        f         = '0;
        f[FLG_TO] = 1'b1;
        f[FLG_NV] = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/fpu_bf16_arbiter_rr.sv
// Rotating-priority picker: first request above last_i, wrapping.
// Purely combinational; produces a one-hot grant and its index.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    int cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last_i) + k) % NREQ;
            if (!any_o && req_i[IW'(cand)]) begin
                any_o              = 1'b1;
                gnt_o[IW'(cand)]   = 1'b1;
                idx_o              = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/fpu_bf16_arbiter.sv
// Shares one bf16 FPU between NREQ requesters: round-robin accept,
// one-cycle issue, bounded wait for done, one-cycle response.
module fpu_bf16_arbiter
    import fpu_bf16_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                   clock,
    input  logic                   resetb,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*OP_W-1:0]   req_op,
    input  logic [NREQ*DATA_W-1:0] req_a,
    input  logic [NREQ*DATA_W-1:0] req_b,
    input  logic [NREQ*DATA_W-1:0] req_c,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_data,
    output logic [RFLAG_W-1:0]     rsp_flags,
    output logic                   fpu_start,
    output logic [OP_W-1:0]        fpu_op,
    output logic [DATA_W-1:0]      fpu_a,
    output logic [DATA_W-1:0]      fpu_b,
    output logic [DATA_W-1:0]      fpu_c,
    input  logic                   fpu_done,
    input  logic [DATA_W-1:0]      fpu_result,
    input  logic [FLAG_W-1:0]      fpu_flags,
    output logic                   busy
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    // First WAIT cycle is one cycle after the start pulse, so the
    // forced response lands exactly TIMEOUT cycles after it.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);

    state_e              state_q;
    logic [IW-1:0]       last_q;
    logic [IW-1:0]       gidx_q;
    logic [NREQ-1:0]     own_q;
    logic [CW-1:0]       cnt_q;
    logic [CW-1:0]       cnt_d;
    logic [OP_W-1:0]     op_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   c_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [RFLAG_W-1:0]  rflags_q;
    logic                start_q;
    logic [NREQ-1:0]     rvld_q;

    logic [NREQ-1:0]     g_gnt;
    logic [IW-1:0]       g_idx;
    logic                g_any;
    logic [OP_W-1:0]     sel_op;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;
    logic [DATA_W-1:0]   sel_c;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req_i  (req_valid),
        .last_i (last_q),
        .gnt_o  (g_gnt),
        .idx_o  (g_idx),
        .any_o  (g_any)
    );

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        sel_c  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (g_gnt[i]) begin
                sel_op = req_op[i*OP_W +: OP_W];
                sel_a  = req_a[i*DATA_W +: DATA_W];
                sel_b  = req_b[i*DATA_W +: DATA_W];
                sel_c  = req_c[i*DATA_W +: DATA_W];
            end
        end
    end

    assign cnt_d = cnt_q + 1'b1;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q  <= S_IDLE;
            last_q   <= IW'(NREQ - 1);
            gidx_q   <= '0;
            own_q    <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            rdata_q  <= '0;
            rflags_q <= '0;
            start_q  <= 1'b0;
            rvld_q   <= '0;
        end else begin
            start_q <= 1'b0;
            rvld_q  <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (g_any) begin
                        op_q    <= sel_op;
                        a_q     <= sel_a;
                        b_q     <= sel_b;
                        c_q     <= sel_c;
                        gidx_q  <= g_idx;
                        own_q   <= g_gnt;
                        start_q <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    cnt_q <= cnt_d;
                    if (fpu_done) begin
                        rdata_q  <= fpu_result;
                        rflags_q <= {1'b0, fpu_flags};
                        rvld_q   <= own_q;
                        state_q  <= S_RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        rdata_q  <= BF16_QNAN;
                        rflags_q <= timeout_flags();
                        rvld_q   <= own_q;
                        state_q  <= S_RESP;
                    end
                end
                S_RESP: begin
                    last_q  <= gidx_q;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == S_IDLE) ? g_gnt : '0;
    assign rsp_valid = rvld_q;
    assign rsp_data  = rdata_q;
    assign rsp_flags = rflags_q;
    assign fpu_start = start_q;
    assign fpu_op    = op_q;
    assign fpu_a     = a_q;
    assign fpu_b     = b_q;
    assign fpu_c     = c_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_fpu_bf16_arbiter.sv
// Scoreboard bench for fpu_bf16_arbiter with an FPU stand-in,
// a round-robin reference and per-requester expected queues.
module tb_fpu_bf16_arbiter;

    localparam int NREQ    = 2;
    localparam int TIMEOUT = 64;
    localparam int NEVER   = 1000;

    logic                   clock = 1'b0;
    logic                   resetb;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*5-1:0]      req_op;
    logic [NREQ*16-1:0]     req_a;
    logic [NREQ*16-1:0]     req_b;
    logic [NREQ*16-1:0]     req_c;
    logic [NREQ-1:0]        rsp_valid;
    logic [15:0]            rsp_data;
    logic [5:0]             rsp_flags;
    logic                   fpu_start;
    logic [4:0]             fpu_op;
    logic [15:0]            fpu_a;
    logic [15:0]            fpu_b;
    logic [15:0]            fpu_c;
    logic                   fpu_done;
    logic [15:0]            fpu_result;
    logic [4:0]             fpu_flags;
    logic                   busy;

    fpu_bf16_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock      (clock),
        .resetb     (resetb),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_c      (req_c),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_flags  (rsp_flags),
        .fpu_start  (fpu_start),
        .fpu_op     (fpu_op),
        .fpu_a      (fpu_a),
        .fpu_b      (fpu_b),
        .fpu_c      (fpu_c),
        .fpu_done   (fpu_done),
        .fpu_result (fpu_result),
        .fpu_flags  (fpu_flags),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    logic        dv  [NREQ];
    logic [4:0]  dop [NREQ];
    logic [15:0] da  [NREQ];
    logic [15:0] db  [NREQ];
    logic [15:0] dc  [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]        = dv[i];
            req_op[i*5 +: 5]    = dop[i];
            req_a[i*16 +: 16]   = da[i];
            req_b[i*16 +: 16]   = db[i];
            req_c[i*16 +: 16]   = dc[i];
        end
    end

    typedef struct {
        logic [15:0] data;
        logic [5:0]  flags;
        int          cyc;
    } exp_t;

    exp_t exp_q [NREQ][$];
    int   glog[$];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          lat_force = -1;
    int          epoch = 0;
    bit          ovr_en = 1'b0;
    logic [15:0] ovr_res = '0;
    logic [4:0]  ovr_flg = '0;

    always @(posedge clock) cyc++;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic int lat_of(input logic [15:0] c);
        return (lat_force >= 0) ? lat_force : 1 + int'(c[2:0]);
    endfunction

    // Behaviour of the FPU stand-in: {result, flags}
    function automatic logic [20:0] fpu_fn(input logic [4:0] op,
        input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        logic [15:0] r;
        if (ovr_en) return {ovr_res, ovr_flg};
        r = (a + b) ^ (c << 1) ^ {11'd0, op};
        return {r, a[4:0] ^ b[4:0] ^ op};
    endfunction

    // FPU stand-in: one operation at a time, done after lat_of(c)
    logic [4:0]  m_o;
    logic [15:0] m_a, m_b, m_c;
    int          m_l, m_ep;

    initial begin
        fpu_done   = 1'b0;
        fpu_result = '0;
        fpu_flags  = '0;
        forever begin
            @(negedge clock);
            if (resetb && fpu_start) begin
                m_o  = fpu_op;
                m_a  = fpu_a;
                m_b  = fpu_b;
                m_c  = fpu_c;
                m_l  = lat_of(fpu_c);
                m_ep = epoch;
                if (m_l < NEVER) begin
                    repeat (m_l) @(posedge clock);
                    #1;
                    {fpu_result, fpu_flags} = fpu_fn(m_o, m_a, m_b, m_c);
                    fpu_done = 1'b1;
                    if (m_ep == epoch && m_l <= TIMEOUT - 1)
                        chk("operand_hold", {fpu_op, fpu_a, fpu_b, fpu_c},
                            {m_o, m_a, m_b, m_c});
                    @(posedge clock);
                    #1;
                    fpu_done = 1'b0;
                end
            end
        end
    end

    // Monitor: round-robin reference, issue timing and response scoreboard
    int              m_last, start_due, gi, ri, mi;
    bit              m_busy;
    logic [NREQ-1:0] eg;
    logic [4:0]      g_op;
    logic [15:0]     g_a, g_b, g_c;
    exp_t            pe;

    always @(negedge clock) begin
        if (!resetb) begin
            m_last    = NREQ - 1;
            m_busy    = 1'b0;
            start_due = -1;
        end else begin
            chk("busy", busy, m_busy);
            chk("start_pulse", fpu_start, cyc == start_due);
            if (fpu_start)
                chk("issue_regs", {fpu_op, fpu_a, fpu_b, fpu_c},
                    {g_op, g_a, g_b, g_c});
            eg = '0;
            gi = 0;
            if (!m_busy && |req_valid) begin
                for (int k = 1; k <= NREQ; k++) begin
                    mi = (m_last + k) % NREQ;
                    if (req_valid[mi] && eg == '0) begin
                        eg[mi] = 1'b1;
                        gi     = mi;
                    end
                end
                m_busy    = 1'b1;
                start_due = cyc + 1;
                g_op      = req_op[gi*5 +: 5];
                g_a       = req_a[gi*16 +: 16];
                g_b       = req_b[gi*16 +: 16];
                g_c       = req_c[gi*16 +: 16];
                glog.push_back(gi);
            end
            chk("grant", req_ready, eg);
            if (rsp_valid != '0) begin
                chk("rsp_onehot", $onehot(rsp_valid), 1);
                ri = 0;
                for (int i = 0; i < NREQ; i++)
                    if (rsp_valid[i]) ri = i;
                n_cmp++;
                if (exp_q[ri].size() == 0) begin
                    n_bad++;
                    $display("FAIL rsp_spurious: req%0d got %0h expected none",
                             ri, rsp_data);
                end else begin
                    pe = exp_q[ri].pop_front();
                    chk("rsp_data", rsp_data, pe.data);
                    chk("rsp_flags", rsp_flags, pe.flags);
                    chk("rsp_cycle", cyc, pe.cyc);
                end
                m_last = ri;
                m_busy = 1'b0;
            end
        end
    end

    // Requester driver; called and returns at posedge + 1
    task automatic issue(input int r, input logic [4:0] op,
        input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
        input int maxw, input bit must);
        bit          got;
        exp_t        e;
        logic [20:0] f;
        int          l;
        got    = 1'b0;
        dv[r]  = 1'b1;
        dop[r] = op;
        da[r]  = a;
        db[r]  = b;
        dc[r]  = c;
        for (int w = 0; w < maxw && !got; w++) begin
            @(negedge clock);
            if (req_ready[r]) begin
                got = 1'b1;
                l   = lat_of(c);
                f   = fpu_fn(op, a, b, c);
                if (l > TIMEOUT - 1) begin
                    e.data  = 16'h7FC0;
                    e.flags = 6'b110000;
                    e.cyc   = cyc + 1 + TIMEOUT;
                end else begin
                    e.data  = f[20:5];
                    e.flags = {1'b0, f[4:0]};
                    e.cyc   = cyc + 2 + l;
                end
                exp_q[r].push_back(e);
            end
            @(posedge clock);
            #1;
        end
        dv[r] = 1'b0;
        if (must) begin
            n_cmp++;
            if (!got) begin
                n_bad++;
                $display("FAIL accept_timeout: req%0d got no ready, expected one", r);
            end
        end
    endtask

    task automatic wait_drain(input int bound);
        int w;
        int pend;
        w = 0;
        pend = 1;
        while (w < bound && pend != 0) begin
            pend = 0;
            for (int i = 0; i < NREQ; i++) pend += exp_q[i].size();
            if (pend != 0) begin
                @(posedge clock);
                #1;
                w++;
            end
        end
        chk("drain", pend, 0);
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, req_ready, '0);
        chk({tag, "_rsp_valid"}, rsp_valid, '0);
        chk({tag, "_start_busy"}, {fpu_start, busy}, 2'b00);
        chk({tag, "_fpu_regs"}, {fpu_op, fpu_a, fpu_b, fpu_c}, '0);
        chk({tag, "_rsp_regs"}, {rsp_data, rsp_flags}, '0);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #2;
        resetb = 1'b0;
        epoch++;
        for (int i = 0; i < NREQ; i++) exp_q[i].delete();
        repeat (2) @(posedge clock);
        #1;
        resetb = 1'b1;
    endtask

    task automatic rand_req(input int r);
        repeat (8) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clock);
                #1;
            end
            issue(r, 5'($urandom), 16'($urandom), 16'($urandom),
                  16'($urandom), $urandom_range(1, 12), 1'b0);
        end
    endtask

    initial begin
        resetb = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            dv[i]  = 1'b0;
            dop[i] = '0;
            da[i]  = '0;
            db[i]  = '0;
            dc[i]  = '0;
        end
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        @(posedge clock);
        #1;
        resetb = 1'b1;
        @(posedge clock);
        #1;

        // Single FADD, FPU answers 3 cycles after start
        ovr_en = 1'b1;
        ovr_res = 16'h4040;
        ovr_flg = 5'b00000;
        lat_force = 3;
        issue(0, 5'd0, 16'h3F80, 16'h4000, 16'h0000, 50, 1'b1);
        wait_drain(100);

        // Flag passthrough: +inf with OF|NX
        ovr_res = 16'h7F80;
        ovr_flg = 5'b00101;
        lat_force = 2;
        issue(1, 5'd2, 16'h7F00, 16'h7F00, 16'h0000, 50, 1'b1);
        wait_drain(100);

        // Contention straight after reset, then continuous valid
        ovr_en = 1'b0;
        lat_force = 1;
        do_reset();
        glog.delete();
        fork
            issue(0, 5'd1, 16'h1111, 16'h2222, 16'h0001, 50, 1'b1);
            issue(1, 5'd3, 16'h3333, 16'h4444, 16'h0002, 50, 1'b1);
        join
        wait_drain(100);
        chk("contend_first", glog.size() >= 2 ? {glog[0], glog[1]} : 64'hx,
            {32'd0, 32'd1});
        glog.delete();
        lat_force = 2;
        fork
            begin
                issue(0, 5'd4, 16'h0A0A, 16'h0B0B, 16'h0003, 50, 1'b1);
                issue(0, 5'd5, 16'h0C0C, 16'h0D0D, 16'h0004, 50, 1'b1);
            end
            begin
                issue(1, 5'd6, 16'h0E0E, 16'h0F0F, 16'h0005, 50, 1'b1);
                issue(1, 5'd7, 16'h1010, 16'h2020, 16'h0006, 50, 1'b1);
            end
        join
        wait_drain(100);
        chk("rr_len", glog.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < glog.size())
                chk($sformatf("rr_seq%0d", i), glog[i], i % 2);

        // FPU never answers
        lat_force = NEVER;
        issue(0, 5'd0, 16'h1234, 16'h5678, 16'h0000, 50, 1'b1);
        wait_drain(200);

        // Done in the same cycle the timeout would fire
        lat_force = TIMEOUT - 1;
        issue(1, 5'd9, 16'hABCD, 16'h0123, 16'h0007, 50, 1'b1);
        wait_drain(200);

        // Done arriving after the timeout response
        lat_force = TIMEOUT + 2;
        issue(0, 5'd8, 16'h4321, 16'h8765, 16'h0000, 50, 1'b1);
        for (int w = 0; w < 120 && !fpu_done; w++) @(negedge clock);
        chk("late_done_seen", fpu_done, 1);
        chk("late_done_busy", busy, 0);
        chk("late_done_rsp", rsp_valid, '0);
        @(posedge clock);
        #1;
        wait_drain(50);
        chk("late_rsp_held", {rsp_data, rsp_flags}, {16'h7FC0, 6'b110000});

        // Reset while waiting on the FPU, then a fresh op from req1
        lat_force = 20;
        issue(0, 5'd2, 16'h5555, 16'h6666, 16'h0000, 50, 1'b1);
        repeat (6) @(posedge clock);
        #2;
        resetb = 1'b0;
        epoch++;
        #1;
        check_reset_outputs("midrst");
        for (int i = 0; i < NREQ; i++) exp_q[i].delete();
        repeat (2) @(posedge clock);
        #1;
        resetb = 1'b1;
        repeat (25) @(posedge clock);
        #1;
        lat_force = 4;
        issue(1, 5'd3, 16'h7777, 16'h8888, 16'h0009, 50, 1'b1);
        wait_drain(100);

        // Randomised traffic with drop-before-grant allowed
        lat_force = -1;
        fork
            rand_req(0);
            rand_req(1);
        join
        wait_drain(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

endmodule
